// File: rtl/keypad_scanner.sv
// Row-strobed matrix keypad scanner with synchronized column sense, press/release
// debounce, optional auto-repeat and multi-key detection.
module keypad_scanner #(
  parameter int ROWS            = 3,
  parameter int COLS            = 3,
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_CYCLES   = 0,
  localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              hwclk,
  input  logic              rst,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_err
);

  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W    = $clog2(SCAN_DIV);
  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_t;

  state_t            state, state_d;
  logic [RW-1:0]     row_idx, row_d, row_next;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [DEB_W-1:0]  deb_cnt, deb_d;
  logic [REP_W-1:0]  rep_cnt, rep_d;
  logic [CW-1:0]     lcol, lcol_d, first_low;
  logic [CODE_W-1:0] code_d;
  logic              valid_d, release_d, multi_d;
  logic [COLS-1:0]   col_meta, col_s;
  logic [3:0]        low_cnt;
  logic              col_hit;

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // decisions live in the always_comb below so this block is a plain register bank.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state       <= SCAN;
      row_idx     <= '0;
      div_cnt     <= '0;
      deb_cnt     <= '0;
      rep_cnt     <= '0;
      lcol        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      multi_err   <= 1'b0;
      col_meta    <= '1;
      col_s       <= '1;
    end else begin
      state       <= state_d;
      row_idx     <= row_d;
      div_cnt     <= div_d;
      deb_cnt     <= deb_d;
      rep_cnt     <= rep_d;
      lcol        <= lcol_d;
      key_code    <= code_d;
      key_valid   <= valid_d;
      key_release <= release_d;
      multi_err   <= multi_d;
      col_meta    <= col_n;
      col_s       <= col_meta;
    end
  end

  assign row_n    = ~(ROWS'(1) << row_idx);
  assign key_held = (state == HELD) || (state == DEB_RELEASE);
  assign col_hit  = ~col_s[lcol];
  assign row_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;

  // Lowest-index low column wins; the count only flags simultaneous presses.
  always_comb begin
    first_low = '0;
    low_cnt   = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_s[i]) begin
        first_low = CW'(i);
        low_cnt   = low_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    row_d     = row_idx;
    div_d     = div_cnt;
    deb_d     = deb_cnt;
    rep_d     = rep_cnt;
    lcol_d    = lcol;
    code_d    = key_code;
    valid_d   = 1'b0;
    release_d = 1'b0;
    multi_d   = 1'b0;

    case (state)
      SCAN: begin
        if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
          if (low_cnt != 4'd0) begin
            state_d = DEB_PRESS;
            lcol_d  = first_low;
            deb_d   = '0;
            multi_d = (low_cnt > 4'd1);
          end else begin
            div_d = '0;
            row_d = row_next;
          end
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (col_hit) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = HELD;
            valid_d = 1'b1;
            code_d  = CODE_W'(int'(row_idx) * COLS + int'(lcol));
            rep_d   = '0;
          end else begin
            deb_d = deb_cnt + 1'b1;
          end
        end else begin
          state_d = SCAN;
          row_d   = row_next;
          div_d   = '0;
        end
      end

      HELD: begin
        if (!col_hit) begin
          state_d = DEB_RELEASE;
          deb_d   = '0;
        end else if (REPEAT_CYCLES > 0) begin
          if (rep_cnt == REP_W'(REP_LAST)) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_cnt + 1'b1;
          end
        end
      end

      DEB_RELEASE: begin
        // A bounce back to low resumes HELD with the repeat phase preserved.
        if (col_hit) begin
          state_d = HELD;
        end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d   = SCAN;
          release_d = 1'b1;
          row_d     = row_next;
          div_d     = '0;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

endmodule
